// File: rtl/matmul_result_drain.sv
// matmul_result_drain: buffers 2x2 result sets from the multiplier in a small
// FIFO and streams each set as four DATA_W words (c00, c01, c10, c11) over a
// valid/ready interface. Sets arriving while the FIFO is full are dropped and
// counted in a saturating counter with a sticky error flag.
module matmul_result_drain #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  input  logic              done,
  input  logic              overflow,
  input  logic              clr_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              out_ovf,
  output logic              busy,
  output logic              drop_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  // Result-set storage; contents are only observed while the FIFO is non-empty,
  // so the array itself carries no reset.
  logic [DATA_W-1:0] r_mem_d   [DEPTH][4];
  logic              r_mem_ovf [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [1:0]        r_idx;
  logic              r_drop_err;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic w_busy;
  logic w_hs;
  logic w_pop;
  logic w_space;
  logic w_push;
  logic w_drop;

  // Saturating increment for the drop counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else return v + CNT_W'(1);
  endfunction

  assign w_busy  = (r_count != '0);
  assign w_hs    = w_busy & out_ready;
  assign w_pop   = w_hs & (r_idx == 2'd3);
  // A full FIFO still accepts a set when the head's last word leaves this cycle.
  assign w_space = (r_count < DEPTH_C) | w_pop;
  assign w_push  = done & w_space;
  assign w_drop  = done & ~w_space;

  // Capture a result set into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wr_ptr][0] <= c00;
      r_mem_d[r_wr_ptr][1] <= c01;
      r_mem_d[r_wr_ptr][2] <= c10;
      r_mem_d[r_wr_ptr][3] <= c11;
      r_mem_ovf[r_wr_ptr]  <= overflow;
    end
  end

  // FIFO pointers, occupancy and the element index of the head set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_idx    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      if (w_hs)   r_idx <= r_idx + 2'd1;
    end
  end

  // Drop bookkeeping; a drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_err <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
      r_drop_cnt <= clr_err ? CNT_W'(1) : sat_inc(r_drop_cnt);
    end else if (clr_err) begin
      r_drop_err <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Stream outputs come straight from registered state, gated to zero when empty.
  always_comb begin
    out_valid = w_busy;
    busy      = w_busy;
    out_idx   = r_idx;
    out_last  = w_busy & (r_idx == 2'd3);
    out_data  = w_busy ? r_mem_d[r_rd_ptr][r_idx] : '0;
    out_ovf   = w_busy & r_mem_ovf[r_rd_ptr];
    drop_err  = r_drop_err;
    drop_cnt  = r_drop_cnt;
  end

endmodule
